// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
// Bit-serial adder/subtractor. Operands are shifted out LSB first and one
// full-add step is done per clock on a single registered carry. A result of
// WIDTH bits is committed WIDTH cycles after the start request is accepted.
// Subtraction is done as a + ~b + ~borrow_in, so carry_out is the not-borrow
// flag.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   start      - request a new operation (only looked at while idle)
//   mode       - 0 = add, 1 = subtract
//   a, b       - operands, captured on the accepting edge
//   carry_in   - carry-in (add) or borrow-in (subtract)
//   busy       - high while an operation is in progress
//   done       - one-cycle pulse when a result is committed
//   sum        - registered result, held until the next commit
//   carry_out  - carry out of the MSB (not-borrow for subtract)
//   overflow   - two's-complement overflow of the committed operation
// -----------------------------------------------------------------------------
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aShift_q, aShift_d;
    logic [WIDTH-1:0] bShift_q, bShift_d;
    logic [WIDTH-1:0] partial_q, partial_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    bitCnt_q, bitCnt_d;
    logic             carry_q, carry_d;
    logic             carryOut_q, carryOut_d;
    logic             overflow_q, overflow_d;
    logic             done_q, done_d;

    logic             stepSum;
    logic             stepCarry;
    logic             lastStep;

    // State and datapath registers; reset clears everything and abandons any
    // operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            aShift_q   <= '0;
            bShift_q   <= '0;
            partial_q  <= '0;
            sum_q      <= '0;
            bitCnt_q   <= '0;
            carry_q    <= 1'b0;
            carryOut_q <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            aShift_q   <= aShift_d;
            bShift_q   <= bShift_d;
            partial_q  <= partial_d;
            sum_q      <= sum_d;
            bitCnt_q   <= bitCnt_d;
            carry_q    <= carry_d;
            carryOut_q <= carryOut_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // One full-add step on the current low bits and the registered carry.
    always_comb begin
        stepSum   = aShift_q[0] ^ bShift_q[0] ^ carry_q;
        stepCarry = (aShift_q[0] & bShift_q[0]) |
                    (aShift_q[0] & carry_q)     |
                    (bShift_q[0] & carry_q);
        lastStep  = (bitCnt_q == LAST_BIT);
    end

    // Next-state logic: accept a request while idle, run WIDTH steps, return.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (lastStep) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values. Subtraction inverts b and the borrow at capture
    // time so the step logic is a plain full adder. On the last step the
    // registered carry is the carry into the MSB, so overflow is formed from
    // it and the carry leaving the MSB on the same edge.
    always_comb begin
        aShift_d   = aShift_q;
        bShift_d   = bShift_q;
        partial_d  = partial_q;
        sum_d      = sum_q;
        bitCnt_d   = bitCnt_q;
        carry_d    = carry_q;
        carryOut_d = carryOut_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    aShift_d  = a;
                    bShift_d  = mode ? ~b : b;
                    carry_d   = mode ? ~carry_in : carry_in;
                    partial_d = '0;
                    bitCnt_d  = '0;
                end
            end
            RUN: begin
                partial_d = {stepSum, partial_q[WIDTH-1:1]};
                aShift_d  = aShift_q >> 1;
                bShift_d  = bShift_q >> 1;
                carry_d   = stepCarry;
                bitCnt_d  = bitCnt_q + CW'(1);
                if (lastStep) begin
                    sum_d      = {stepSum, partial_q[WIDTH-1:1]};
                    carryOut_d = stepCarry;
                    overflow_d = carry_q ^ stepCarry;
                    done_d     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs; busy follows the state so it can never overlap the done pulse.
    always_comb begin
        busy      = (state_q == RUN);
        done      = done_q;
        sum       = sum_q;
        carry_out = carryOut_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
// Self-checking bench for serial_add_sub. A WIDTH=8 instance runs directed
// add/subtract/handshake/reset cases; a WIDTH=2 instance is swept over all
// 64 combinations of a, b, carry_in and mode against an arithmetic model.
// Expected results go into a queue when an operation is started and are
// popped when the matching done pulse appears.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, mode8, carryIn8;
    logic [7:0] a8, b8;
    logic       busy8, done8, carryOut8, overflow8;
    logic [7:0] sum8;

    logic       start2, mode2, carryIn2;
    logic [1:0] a2, b2;
    logic       busy2, done2, carryOut2, overflow2;
    logic [1:0] sum2;

    exp_t       sbQ[$];
    int         testsRun = 0;
    int         testsFailed = 0;
    int         cyc = 0;
    int         accCyc = 0;
    int         lastDoneCyc = 0;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8),
        .a(a8), .b(b8), .carry_in(carryIn8),
        .busy(busy8), .done(done8), .sum(sum8),
        .carry_out(carryOut8), .overflow(overflow8)
    );

    serial_add_sub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2),
        .a(a2), .b(b2), .carry_in(carryIn2),
        .busy(busy2), .done(done2), .sum(sum2),
        .carry_out(carryOut2), .overflow(overflow2)
    );

    // Free-running clock and an edge counter used for latency measurements.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts, and reports on mismatch.
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference for the 2-bit instance, straight integer arithmetic.
    function automatic exp_t model2(input logic [7:0] av, input logic [7:0] bv,
                                    input logic m, input logic cin);
        exp_t       r;
        logic [1:0] bb;
        logic       c0;
        int         full;
        bb     = m ? ~bv[1:0] : bv[1:0];
        c0     = m ? ~cin : cin;
        full   = int'(av[1:0]) + int'(bb) + int'(c0);
        r.sum  = 8'(full & 3);
        r.cout = full[2];
        r.ovf  = (av[1] == bb[1]) && (r.sum[1] != av[1]);
        return r;
    endfunction

    // Drive one start pulse on the chosen instance and queue its result.
    task automatic applyStimulus(input int w, input logic [7:0] av, input logic [7:0] bv,
                                 input logic m, input logic cin, input exp_t e);
        @(negedge clk);
        if (w == 8) begin
            start8 = 1'b1; a8 = av; b8 = bv; mode8 = m; carryIn8 = cin;
        end else begin
            start2 = 1'b1; a2 = av[1:0]; b2 = bv[1:0]; mode2 = m; carryIn2 = cin;
        end
        sbQ.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        start2 = 1'b0;
        accCyc = cyc;
        checkVal($sformatf("w%0d.busyAfterStart", w), (w == 8) ? busy8 : busy2, 1);
    endtask

    // Wait (bounded) for done, then pop and compare the oldest expectation.
    task automatic checkOutput(input int w, input string tag);
        int         k;
        logic       dn;
        exp_t       e;
        logic [7:0] obsSum;
        k  = 0;
        dn = (w == 8) ? done8 : done2;
        while (dn !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            dn = (w == 8) ? done8 : done2;
        end
        if (sbQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $error("[TB] FAIL %s.queue: observed empty expected an entry", tag);
            return;
        end
        e = sbQ.pop_front();
        if (dn !== 1'b1) begin
            testsRun++;
            testsFailed++;
            $error("[TB] FAIL %s.timeout: observed no done expected done within 40 cycles", tag);
            return;
        end
        lastDoneCyc = cyc;
        obsSum = (w == 8) ? sum8 : {6'b0, sum2};
        checkVal({tag, ".sum"}, obsSum, e.sum);
        checkVal({tag, ".cout"}, (w == 8) ? carryOut8 : carryOut2, e.cout);
        checkVal({tag, ".ovf"}, (w == 8) ? overflow8 : overflow2, e.ovf);
        checkVal({tag, ".busyWithDone"}, (w == 8) ? busy8 : busy2, 0);
        checkVal({tag, ".latency"}, cyc - accCyc, w);
    endtask

    // Directed sequence.
    initial begin
        int   prevDone;
        logic sawDone;

        rst = 1'b1;
        start8 = 1'b0; mode8 = 1'b0; carryIn8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; mode2 = 1'b0; carryIn2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        checkVal("rst.busy8", busy8, 0);
        checkVal("rst.done8", done8, 0);
        checkVal("rst.sum8", sum8, 0);
        checkVal("rst.cout8", carryOut8, 0);
        checkVal("rst.ovf8", overflow8, 0);
        checkVal("rst.busy2", busy2, 0);
        checkVal("rst.sum2", sum2, 0);
        rst = 1'b0;

        // Plain add with signed overflow; done must be a single-cycle pulse.
        applyStimulus(8, 8'h5A, 8'h3C, 1'b0, 1'b0, '{8'h96, 1'b0, 1'b1});
        checkOutput(8, "add5A3C");
        @(negedge clk);
        checkVal("add5A3C.donePulse", done8, 0);

        // Wrap-around and carry-in driven overflow.
        applyStimulus(8, 8'hFF, 8'h01, 1'b0, 1'b0, '{8'h00, 1'b1, 1'b0});
        checkOutput(8, "addFF01");
        applyStimulus(8, 8'h7F, 8'h00, 1'b0, 1'b1, '{8'h80, 1'b0, 1'b1});
        checkOutput(8, "add7F00c1");

        // Subtract with borrow, then subtract with overflow.
        applyStimulus(8, 8'h10, 8'h20, 1'b1, 1'b0, '{8'hF0, 1'b0, 1'b0});
        checkOutput(8, "sub1020");
        applyStimulus(8, 8'h80, 8'h01, 1'b1, 1'b0, '{8'h7F, 1'b1, 1'b1});
        checkOutput(8, "sub8001");

        // Start and operand changes during RUN are ignored.
        applyStimulus(8, 8'h03, 8'h04, 1'b0, 1'b0, '{8'h07, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; mode8 = 1'b1; carryIn8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; mode8 = 1'b0; carryIn8 = 1'b0;
        checkOutput(8, "ignoreStart");

        // start held high through the done cycle: second op accepted at once.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; mode8 = 1'b0; carryIn8 = 1'b0;
        sbQ.push_back('{8'h33, 1'b0, 1'b0});
        @(negedge clk);
        accCyc = cyc;
        a8 = 8'h80; b8 = 8'h80; carryIn8 = 1'b1;
        sbQ.push_back('{8'h01, 1'b1, 1'b1});
        checkOutput(8, "b2bFirst");
        prevDone = lastDoneCyc;
        @(negedge clk);
        start8 = 1'b0; carryIn8 = 1'b0;
        accCyc = cyc;
        checkVal("b2b.busySecond", busy8, 1);
        checkVal("b2b.sumHold", sum8, 8'h33);
        checkOutput(8, "b2bSecond");
        checkVal("b2b.spacing", lastDoneCyc - prevDone, 9);

        // Reset at RUN step 3 abandons the operation.
        applyStimulus(8, 8'h12, 8'h34, 1'b0, 1'b0, '{8'h46, 1'b0, 1'b0});
        void'(sbQ.pop_front());
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkVal("midRst.busy", busy8, 0);
        checkVal("midRst.done", done8, 0);
        checkVal("midRst.sum", sum8, 0);
        checkVal("midRst.cout", carryOut8, 0);
        checkVal("midRst.ovf", overflow8, 0);
        sawDone = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) sawDone = 1'b1;
        end
        checkVal("midRst.noDone", sawDone, 0);
        applyStimulus(8, 8'h12, 8'h34, 1'b0, 1'b0, '{8'h46, 1'b0, 1'b0});
        checkOutput(8, "afterRst");

        // Exhaustive sweep of the 2-bit instance.
        for (int i = 0; i < 64; i++) begin
            logic [7:0] av;
            logic [7:0] bv;
            av = 8'(i & 3);
            bv = 8'((i >> 2) & 3);
            applyStimulus(2, av, bv, i[5], i[4], model2(av, bv, i[5], i[4]));
            checkOutput(2, $sformatf("w2.case%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised bit-serial adder/subtractor, LSB first: one full-add step per clock on a single registered carry.
- Successor to the single-bit full adder. Replaces a WIDTH-wide ripple chain with a shift datapath plus a start/busy/done handshake.
- Used where area matters more than latency, e.g. in accumulators and low-rate arithmetic units.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- mode  input  1  0 = add (a + b + carry_in); 1 = subtract (a - b - carry_in).
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- carry_in  input  1  carry-in for add, borrow-in for subtract; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when a result is committed.
- sum  output  WIDTH  registered result; holds until the next commit.
- carry_out  output  1  carry out of the MSB. For subtract it is the not-borrow flag (1 = no borrow).
- overflow  output  1  two's-complement overflow of the operation.

Behaviour:
- States: IDLE and RUN. The bit counter runs 0..WIDTH-1.
- IDLE, start=1 at edge T0:
  - Capture a into the A shift register.
  - Capture b into the B shift register; b is inverted when mode=1.
  - Initialise carry to carry_in (add) or ~carry_in (sub).
  - Clear the counter, set busy=1, go to RUN.
- RUN, at edge T0+1+i (i = 0..WIDTH-1):
  - Form s = A[0] ^ B[0] ^ carry and the new carry by the full-add majority of the same three bits.
  - Shift s into the partial-result register MSB-first, so that after WIDTH steps bit i sits at position i.
  - Shift A and B right by one; increment the counter.
  - At step i = WIDTH-1, record the carry into the MSB (the carry before the step) for the overflow calculation.
- Completion at edge T0+WIDTH (the final step):
  - sum <= the complete partial result; carry_out <= final carry.
  - overflow <= (carry into MSB) XOR (carry out of MSB).
  - done=1 and busy=0 for the following cycle; state returns to IDLE.
- Latency: done is high in the cycle after edge T0+WIDTH, i.e. WIDTH cycles after the accepting edge.
- done and busy are never high together.
- start while busy=1 is ignored. Operands, mode and carry_in changing during RUN have no effect.
- start=1 in the done cycle is accepted, since the state is IDLE. Back-to-back operations therefore sustain a throughput of one per WIDTH+1 cycles.
- sum, carry_out and overflow change only at a commit edge or at reset. They hold otherwise, including during the next RUN.
- Reset (rst=1 at any edge, including mid-RUN):
  - State IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0; counter and shift registers cleared.
  - An in-flight operation is abandoned; no done is produced for it.
- rst has priority over start on the same edge.

Test Plan (WIDTH=8 unless stated):
1. Add, mode=0, a=8'h5A, b=8'h3C, carry_in=0, start pulsed one cycle -> busy high for 8 cycles, then done for exactly 1 cycle; sum=8'h96, carry_out=0, overflow=1.
2. Add with wrap, a=8'hFF, b=8'h01, carry_in=0 -> sum=8'h00, carry_out=1, overflow=0. Then a=8'h7F, b=8'h00, carry_in=1 -> sum=8'h80, overflow=1.
3. Subtract, mode=1, a=8'h10, b=8'h20, carry_in=0 -> sum=8'hF0, carry_out=0 (borrow), overflow=0. Then a=8'h80, b=8'h01 -> sum=8'h7F, carry_out=1, overflow=1.
4. Handshake:
   - Start a=8'h03, b=8'h04; at cycle 3 of RUN drive start=1 with a=8'hAA -> ignored; result sum=8'h07.
   - start held high through the done cycle -> a second operation is accepted immediately, and its done arrives 9 cycles after the first done.
5. Reset mid-run: start a=8'h12, b=8'h34; assert rst for 1 cycle at RUN step 3 -> busy=0, done stays 0, sum=0. Next op a=8'h12, b=8'h34 -> sum=8'h46.
6. WIDTH=2 instance: exhaustive a, b, carry_in, mode (64 cases) against a reference model -> sum, carry_out and overflow match; done latency is 2 cycles in every case.
